// File: rtl/urisc_core.sv
// urisc_core: single-instruction CPU core (subtract and branch if negative).
//   Each instruction is three 9-bit words A, B, C fetched from instruction ROM:
//     Mem[B] <= Mem[B] - Mem[A]; if the result is negative, PC <= C.
//   A single 9-bit address bus (MAR) is shared by a 512x16 data RAM and a
//   512-word instruction ROM. Both are read synchronously: the read data is
//   valid in the cycle after the one in which CS and Read are high.
// Ports:
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous active-high reset
//   Run       in   1   start pulse, sampled only in IDLE
//   Stop      in   1   halt request, takes effect after the current instruction
//   Data_in   in  16   data RAM read data
//   Inst_in   in   9   instruction ROM read data
//   Data_CS   out  1   data RAM select
//   Inst_CS   out  1   instruction ROM select
//   Read      out  1   read strobe, shared by both memories
//   Write     out  1   write strobe, data RAM only
//   MAR       out  9   memory address
//   Data_out  out 16   write data (result register)
//   State     out  4   current FSM state code
module urisc_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        Run,
   input  logic        Stop,
   input  logic [15:0] Data_in,
   input  logic [8:0]  Inst_in,
   output logic        Data_CS,
   output logic        Inst_CS,
   output logic        Read,
   output logic        Write,
   output logic [8:0]  MAR,
   output logic [15:0] Data_out,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_FA   = 4'd1,
      S_LA   = 4'd2,
      S_FB   = 4'd3,
      S_LB   = 4'd4,
      S_FC   = 4'd5,
      S_LC   = 4'd6,
      S_RA   = 4'd7,
      S_LDA  = 4'd8,
      S_RB   = 4'd9,
      S_SUB  = 4'd10,
      S_WB   = 4'd11,
      S_BR   = 4'd12
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [8:0]  pc_reg;
   logic [8:0]  a_reg;
   logic [8:0]  b_reg;
   logic [8:0]  c_reg;
   logic [15:0] r_reg;
   logic [15:0] res_reg;
   logic        stop_pend_reg;

   // Stop is only latched while an instruction is in flight (states 1..11);
   // in BR it is looked at directly, so a request in the last cycle still counts.
   logic        in_flight;
   assign in_flight = (state_reg >= S_FA) && (state_reg <= S_WB);

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         pc_reg        <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         c_reg         <= '0;
         r_reg         <= '0;
         res_reg       <= '0;
         stop_pend_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (Run && !Stop) begin
                  pc_reg        <= '0;
                  stop_pend_reg <= 1'b0;
               end
            end
            S_LA: begin
               a_reg  <= Inst_in;
               pc_reg <= pc_reg + 9'd1;   // wraps modulo 512
            end
            S_LB: begin
               b_reg  <= Inst_in;
               pc_reg <= pc_reg + 9'd1;
            end
            S_LC: begin
               c_reg  <= Inst_in;
               pc_reg <= pc_reg + 9'd1;
            end
            S_LDA: r_reg   <= Data_in;
            S_SUB: res_reg <= Data_in - r_reg;   // modulo 2^16
            S_BR: begin
               if (res_reg[15]) pc_reg <= c_reg;
            end
            default: ;
         endcase
         if (in_flight && Stop) stop_pend_reg <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = S_IDLE;
      case (state_reg)
         S_IDLE: state_next = (Run && !Stop) ? S_FA : S_IDLE;
         S_FA:   state_next = S_LA;
         S_LA:   state_next = S_FB;
         S_FB:   state_next = S_LB;
         S_LB:   state_next = S_FC;
         S_FC:   state_next = S_LC;
         S_LC:   state_next = S_RA;
         S_RA:   state_next = S_LDA;
         S_LDA:  state_next = S_RB;
         S_RB:   state_next = S_SUB;
         S_SUB:  state_next = S_WB;
         S_WB:   state_next = S_BR;
         S_BR:   state_next = (stop_pend_reg || Stop) ? S_IDLE : S_FA;
         default: state_next = S_IDLE;   // unused codes recover to IDLE
      endcase
   end

   // Moore outputs decoded from the state and registers
   always_comb begin
      Data_CS = 1'b0;
      Inst_CS = 1'b0;
      Read    = 1'b0;
      Write   = 1'b0;
      MAR     = '0;
      case (state_reg)
         S_FA, S_FB, S_FC: begin
            MAR     = pc_reg;
            Inst_CS = 1'b1;
            Read    = 1'b1;
         end
         S_RA: begin
            MAR     = a_reg;
            Data_CS = 1'b1;
            Read    = 1'b1;
         end
         S_RB: begin
            MAR     = b_reg;
            Data_CS = 1'b1;
            Read    = 1'b1;
         end
         S_WB: begin
            MAR     = b_reg;
            Data_CS = 1'b1;
            Write   = 1'b1;
         end
         default: ;
      endcase
   end

   assign Data_out = res_reg;
   assign State    = state_reg;

endmodule

// File: tb/tb_urisc_core.sv
// tb_urisc_core: directed bench for urisc_core with behavioural ROM/RAM models
// and a scoreboard of expected data-RAM writes.
module tb_urisc_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        Run;
   logic        Stop;
   logic [15:0] Data_in;
   logic [8:0]  Inst_in;
   logic        Data_CS;
   logic        Inst_CS;
   logic        Read;
   logic        Write;
   logic [8:0]  MAR;
   logic [15:0] Data_out;
   logic [3:0]  State;

   int checks   = 0;
   int failures = 0;

   logic [8:0]  rom [0:511];
   logic [15:0] ram [0:511];

   typedef struct {
      logic [8:0]  addr;
      logic [15:0] data;
   } wr_t;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   urisc_core dut (
      .clk      (clk),
      .reset    (reset),
      .Run      (Run),
      .Stop     (Stop),
      .Data_in  (Data_in),
      .Inst_in  (Inst_in),
      .Data_CS  (Data_CS),
      .Inst_CS  (Inst_CS),
      .Read     (Read),
      .Write    (Write),
      .MAR      (MAR),
      .Data_out (Data_out),
      .State    (State)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Synchronous memory models
   always @(posedge clk) begin
      if (Inst_CS && Read) Inst_in <= rom[MAR];
      if (Data_CS && Read) Data_in <= ram[MAR];
      if (Data_CS && Write) ram[MAR] = Data_out;
   end

   // Write scoreboard and bus exclusivity checks
   always @(posedge clk) begin
      chk("rd_wr_excl", {31'd0, Read & Write}, 32'd0);
      chk("cs_excl", {31'd0, Data_CS & Inst_CS}, 32'd0);
      if (Data_CS && Write) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", {23'd0, MAR}, 32'h1FF_FFFF);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("write_addr", {23'd0, MAR}, {23'd0, w.addr});
            chk("write_data", {16'd0, Data_out}, {16'd0, w.data});
            $display("write addr=%0d data=%04h (expected addr=%0d data=%04h)",
                     MAR, Data_out, w.addr, w.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Executes one instruction starting in FA.
   // mode 0: normal, 1: Stop pulsed in LB, 2: reset asserted in WB.
   task automatic run_instr(input logic [8:0] pc, input logic [8:0] b_addr,
                            input logic [15:0] res, input logic [8:0] next_pc,
                            input int mode);
      wr_t w;
      w.addr = b_addr;
      w.data = res;
      exp_q.push_back(w);
      chk("fa_state", {28'd0, State}, 32'd1);
      chk("fa_mar", {23'd0, MAR}, {23'd0, pc});
      for (int s = 1; s < 11; s++) begin
         Stop = (mode == 1 && s == 4);
         tick();
      end
      Stop = 1'b0;
      chk("wb_state", {28'd0, State}, 32'd11);
      chk("wb_write", {31'd0, Write}, 32'd1);
      chk("wb_cs", {31'd0, Data_CS}, 32'd1);
      chk("wb_mar", {23'd0, MAR}, {23'd0, b_addr});
      chk("wb_data", {16'd0, Data_out}, {16'd0, res});
      if (mode == 2) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         chk("rst_wb_state", {28'd0, State}, 32'd0);
         chk("rst_wb_write", {31'd0, Write}, 32'd0);
         chk("rst_wb_mar", {23'd0, MAR}, 32'd0);
      end else begin
         tick();
         chk("br_state", {28'd0, State}, 32'd12);
         tick();
         if (mode == 1) begin
            chk("stop_idle", {28'd0, State}, 32'd0);
            for (int i = 0; i < 3; i++) begin
               tick();
               chk("stop_no_fetch", {31'd0, Inst_CS}, 32'd0);
               chk("stop_state", {28'd0, State}, 32'd0);
            end
         end else begin
            chk("next_fetch_cs", {31'd0, Inst_CS}, 32'd1);
            chk("next_fetch_mar", {23'd0, MAR}, {23'd0, next_pc});
         end
      end
      $display("instr pc=%0d b=%0d res=%04h mode=%0d done", pc, b_addr, res, mode);
   endtask

   task automatic pulse_run();
      Run = 1'b1;
      tick();
      Run = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         rom[i] = '0;
         ram[i] = '0;
      end
      Data_in = '0;
      Inst_in = '0;
      reset = 1'b1;
      Run   = 1'b1;
      Stop  = 1'b0;
      tick();
      tick();
      chk("rst_state", {28'd0, State}, 32'd0);
      chk("rst_mar", {23'd0, MAR}, 32'd0);
      chk("rst_dout", {16'd0, Data_out}, 32'd0);
      chk("rst_strobes", {28'd0, Data_CS, Inst_CS, Read, Write}, 32'd0);
      reset = 1'b0;
      Run   = 1'b0;
      tick();
      chk("idle_stays", {28'd0, State}, 32'd0);

      // Branch taken: 3 - 5 = 0xFFFE, jump to 6
      rom[0] = 9'd10; rom[1] = 9'd11; rom[2] = 9'd6;
      ram[10] = 16'd5; ram[11] = 16'd3;
      // Not taken: 5 - 3 = 2, fall through to 9
      rom[6] = 9'd20; rom[7] = 9'd21; rom[8] = 9'd100;
      ram[20] = 16'd3; ram[21] = 16'd5;
      // Zero result: 7 - 7 = 0, fall through to 12
      rom[9] = 9'd30; rom[10] = 9'd31; rom[11] = 9'd100;
      ram[30] = 16'd7; ram[31] = 16'd7;
      // Stop during LB: 9 - 1 = 8, then IDLE
      rom[12] = 9'd40; rom[13] = 9'd41; rom[14] = 9'd0;
      ram[40] = 16'd1; ram[41] = 16'd9;

      pulse_run();
      run_instr(9'd0, 9'd11, 16'hFFFE, 9'd6, 0);
      chk("ram11", {16'd0, ram[11]}, 32'hFFFE);
      run_instr(9'd6, 9'd21, 16'h0002, 9'd9, 0);
      run_instr(9'd9, 9'd31, 16'h0000, 9'd12, 0);
      run_instr(9'd12, 9'd41, 16'h0008, 9'd0, 1);
      chk("ram41", {16'd0, ram[41]}, 32'h0008);

      // Run and Stop together in IDLE: no start
      Run = 1'b1; Stop = 1'b1;
      tick();
      Run = 1'b0; Stop = 1'b0;
      chk("run_stop_idle", {28'd0, State}, 32'd0);

      // Restart at 0 and branch to 510; the instruction at 510 wraps (510,511,0)
      rom[2] = 9'd510;
      ram[10] = 16'd5; ram[11] = 16'd3;
      rom[510] = 9'd50; rom[511] = 9'd51;
      ram[50] = 16'd1; ram[51] = 16'd2;
      ram[510] = 16'd0;
      pulse_run();
      run_instr(9'd0, 9'd11, 16'hFFFE, 9'd510, 0);
      run_instr(9'd510, 9'd51, 16'h0001, 9'd1, 0);
      // Instruction at 1: A=11, B=510, C=rom[3]; 0 - 0xFFFE = 0x0002, reset in WB
      run_instr(9'd1, 9'd510, 16'h0002, 9'd0, 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_idle", {28'd0, State}, 32'd0);
      end
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
